fmap_stream16: RTL and testbench

//  Source side of the 16-channel conv input stream. Reads a MAP_SIZE x MAP_SIZE x 16 feature map

---
 rtl/fmap_stream16_if.sv | 23 ++
 rtl/fmap_stream16.sv | 182 ++++++++++++++++++
 tb/tb_fmap_stream16.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fmap_stream16_if.sv
// Read-buffer bus and conv-engine drive lines of the 16-channel input stream.
// The master side is the streamer; the slave side is the RAM plus conv engine.
interface fmap_stream16_if #(
    parameter int BIT_WIDTH = 8,
    parameter int ADDR_W    = 5
);
    logic                   rd_en;
    logic [ADDR_W-1:0]      rd_addr;
    logic [16*BIT_WIDTH-1:0] rd_data;
    logic [16*BIT_WIDTH-1:0] next;
    logic                   conv_en;
    logic                   conv_rst;

    modport master (
        output rd_en, rd_addr, next, conv_en, conv_rst,
        input  rd_data
    );

    modport slave (
        input  rd_en, rd_addr, next, conv_en, conv_rst,
        output rd_data
    );
endinterface

// File: rtl/fmap_stream16.sv
// Streams one MAP_SIZE x MAP_SIZE x 16 feature map in raster order into the
// 5x5x16 conv engine and flags the cycles where the engine holds a full window.
module fmap_stream16 #(
    parameter int BIT_WIDTH = 8,
    parameter int MAP_SIZE  = 5,
    parameter int KSIZE     = 5,
    parameter int CONV_LAT  = 1,
    parameter int ADDR_W    = 5,
    parameter int CRD_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             hold_i,
    fmap_stream16_if.master  bus,
    output logic             win_valid_o,
    output logic [CRD_W-1:0] out_row_o,
    output logic [CRD_W-1:0] out_col_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int PIX_W  = (MAP_SIZE > 1) ? $clog2(MAP_SIZE) : 1;
    localparam int DCNT_W = $clog2(CONV_LAT + 2);
    localparam logic [PIX_W-1:0]  LAST_PIX   = PIX_W'(MAP_SIZE - 1);
    localparam logic [PIX_W-1:0]  K_OFS      = PIX_W'(KSIZE - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MAP_SIZE * MAP_SIZE - 1);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(CONV_LAT);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [PIX_W-1:0]  row_q, col_q;
    logic [DCNT_W-1:0] drainCnt_q;
    logic              rdEn;
    logic              convRst;
    logic              doneNow;

    logic              convEn_q;
    logic [PIX_W-1:0]  pixRow_q, pixCol_q;

    logic              winIn;
    logic [PIX_W-1:0]  winRowOfs, winColOfs;

    logic              winVld_q [CONV_LAT];
    logic [CRD_W-1:0]  winRow_q [CONV_LAT];
    logic [CRD_W-1:0]  winCol_q [CONV_LAT];

    // State register; an asynchronous reset abandons any map in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sequencing: clear the engine, stream every pixel, let the pipeline flush, then pulse done.
    always_comb begin
        state_d = state_q;
        rdEn    = 1'b0;
        convRst = 1'b0;
        doneNow = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                convRst = 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                rdEn = !hold_i;
                if (rdEn && (addr_q == LAST_ADDR)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drainCnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                doneNow = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read address plus the row/col of the pixel being requested, and the drain timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            drainCnt_q <= '0;
        end else begin
            if (state_q == CLEAR) begin
                addr_q <= '0;
                row_q  <= '0;
                col_q  <= '0;
            end else if (rdEn) begin
                addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                if (col_q == LAST_PIX) begin
                    col_q <= '0;
                    row_q <= (row_q == LAST_PIX) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
            drainCnt_q <= (state_q == DRAIN) ? drainCnt_q + 1'b1 : '0;
        end
    end

    // The RAM answers one cycle after the strobe, so the enable and pixel coordinates follow it by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            convEn_q <= 1'b0;
            pixRow_q <= '0;
            pixCol_q <= '0;
        end else begin
            convEn_q <= rdEn;
            if (rdEn) begin
                pixRow_q <= row_q;
                pixCol_q <= col_q;
            end
        end
    end

    // A pixel completes a window when it is the bottom-right corner of a KSIZE x KSIZE block.
    always_comb begin
        winIn     = convEn_q && (pixRow_q >= K_OFS) && (pixCol_q >= K_OFS);
        winRowOfs = pixRow_q - K_OFS;
        winColOfs = pixCol_q - K_OFS;
    end

    // Delay the window flag and coordinates to line up with the engine's convValue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CONV_LAT; i++) begin
                winVld_q[i] <= 1'b0;
                winRow_q[i] <= '0;
                winCol_q[i] <= '0;
            end
        end else begin
            winVld_q[0] <= winIn;
            winRow_q[0] <= CRD_W'(winRowOfs);
            winCol_q[0] <= CRD_W'(winColOfs);
            for (int i = 1; i < CONV_LAT; i++) begin
                winVld_q[i] <= winVld_q[i-1];
                winRow_q[i] <= winRow_q[i-1];
                winCol_q[i] <= winCol_q[i-1];
            end
        end
    end

    // Output drive; pixel data is forced to zero whenever the engine is not enabled.
    always_comb begin
        bus.rd_en    = rdEn;
        bus.rd_addr  = addr_q;
        bus.conv_en  = convEn_q;
        bus.conv_rst = convRst;
        bus.next     = convEn_q ? bus.rd_data : '0;
        win_valid_o  = winVld_q[CONV_LAT-1];
        out_row_o    = winRow_q[CONV_LAT-1];
        out_col_o    = winCol_q[CONV_LAT-1];
        busy_o       = (state_q != IDLE);
        done_o       = doneNow;
    end
endmodule

// File: tb/tb_fmap_stream16.sv
// Testbench for fmap_stream16 on a 6x6 map with a 5x5 window.
// Stimulus pushes expected reads, pixels and windows into queues; a negedge monitor pops and compares.
module tb_fmap_stream16;
    localparam int BW  = 8;
    localparam int M   = 6;
    localparam int K   = 5;
    localparam int LAT = 1;
    localparam int AW  = 6;
    localparam int CW  = 3;
    localparam int N   = M * M;
    localparam int DW  = 16 * BW;

    typedef struct {
        int            addr;
        logic [DW-1:0] data;
    } pix_t;

    typedef struct {
        int r;
        int c;
    } win_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic hold = 1'b0;
    logic winValid;
    logic [CW-1:0] outRow, outCol;
    logic busy, done;

    fmap_stream16_if #(.BIT_WIDTH(BW), .ADDR_W(AW)) bus ();

    fmap_stream16 #(
        .BIT_WIDTH(BW), .MAP_SIZE(M), .KSIZE(K), .CONV_LAT(LAT), .ADDR_W(AW), .CRD_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .hold_i(hold), .bus(bus),
        .win_valid_o(winValid), .out_row_o(outRow), .out_col_o(outCol),
        .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    int checks = 0;
    int passes = 0;

    logic [DW-1:0] mem [N];
    int   rdQ[$];
    pix_t pixQ[$];
    win_t winQ[$];
    int   mapsOutstanding = 0;
    int   ceCycle [N];
    int   lastRdCycle = 0;
    bit   clearSeen = 0;
    bit   prevDone = 0;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Buffer model: data for a strobed address shows up one cycle later.
    bit pendRd = 0;
    int pendAddr = 0;
    always @(negedge clk) begin
        pendRd   = bus.rd_en;
        pendAddr = int'(bus.rd_addr);
    end
    always @(posedge clk) begin
        #1;
        if (pendRd && pendAddr < N) bus.rd_data = mem[pendAddr];
        else bus.rd_data = {$urandom, $urandom, $urandom, $urandom};
    end

    // Monitor: compares every DUT event against the expectation queues.
    always @(negedge clk) begin
        pix_t p;
        win_t w;
        int   px;
        if (rst_n) begin
            if (bus.rd_en) begin
                checkOutput("rd_expected", DW'(rdQ.size() != 0), 1);
                if (rdQ.size() != 0) checkOutput("rd_addr", DW'(bus.rd_addr), DW'(rdQ.pop_front()));
                lastRdCycle = cycle;
            end
            if (bus.conv_rst) clearSeen = 1;
            if (bus.conv_en) begin
                checkOutput("pix_expected", DW'(pixQ.size() != 0), 1);
                if (pixQ.size() != 0) begin
                    p = pixQ.pop_front();
                    checkOutput("next_data", bus.next, p.data);
                    if (p.addr == 0) checkOutput("clear_before_data", DW'(clearSeen), 1);
                    ceCycle[p.addr] = cycle;
                end
            end
            if (winValid) begin
                checkOutput("win_expected", DW'(winQ.size() != 0), 1);
                if (winQ.size() != 0) begin
                    w = winQ.pop_front();
                    checkOutput("out_row", DW'(outRow), DW'(w.r));
                    checkOutput("out_col", DW'(outCol), DW'(w.c));
                    px = (w.r + K - 1) * M + (w.c + K - 1);
                    checkOutput("win_latency", DW'(cycle - ceCycle[px]), DW'(LAT));
                end
            end
            if (prevDone) checkOutput("busy_fall", DW'(busy), 0);
            if (done) begin
                checkOutput("done_expected", DW'(mapsOutstanding > 0), 1);
                checkOutput("done_after_last_read", DW'(cycle - lastRdCycle), DW'(LAT + 2));
                checkOutput("windows_left", DW'(winQ.size()), 0);
                checkOutput("pixels_left", DW'(pixQ.size()), 0);
                if (mapsOutstanding > 0) mapsOutstanding--;
                clearSeen = 0;
            end
            prevDone = done;
        end else begin
            prevDone = 0;
        end
    end

    // Reference model of one map: every address once in raster order, windows in raster order.
    task automatic loadMap();
        for (int a = 0; a < N; a++) begin
            for (int ch = 0; ch < 16; ch++) mem[a][ch*BW +: BW] = BW'($urandom);
            rdQ.push_back(a);
            pixQ.push_back('{addr: a, data: mem[a]});
        end
        for (int r = 0; r <= M - K; r++)
            for (int c = 0; c <= M - K; c++)
                winQ.push_back('{r: r, c: c});
        mapsOutstanding++;
    endtask

    task automatic flushModel();
        rdQ.delete();
        pixQ.delete();
        winQ.delete();
        mapsOutstanding = 0;
        clearSeen = 0;
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        flushModel();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Runs one map from an idle cycle; returns start-to-done latency or -1 on timeout.
    task automatic applyStimulus(input int holdPct, input int holdFrom, input int holdTo,
                                 input bit extraStarts, input bit startAtDone, output int latency);
        int startCycle;
        int rel;
        bit got;
        loadMap();
        start = 1'b1;
        startCycle = cycle;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_in_clear", DW'(busy), 1);
        got = 0;
        latency = -1;
        for (int i = 0; i < 1000; i++) begin
            if (done) begin
                got = 1;
                break;
            end
            rel = cycle - startCycle;
            hold = (rel >= holdFrom && rel <= holdTo) || ($urandom_range(99) < holdPct);
            start = extraStarts && (rel == 5 || rel == 20 || $urandom_range(7) == 0);
            @(posedge clk); #1;
        end
        checkOutput("map_done_seen", DW'(got), 1);
        hold = 1'b0;
        if (!got) begin
            start = 1'b0;
            pulseReset();
        end else begin
            latency = cycle - startCycle;
            start = startAtDone;
            @(posedge clk); #1;
            start = 1'b0;
            if (startAtDone) begin
                checkOutput("start_at_done_ignored", DW'(busy), 0);
                @(posedge clk); #1;
                checkOutput("still_idle", DW'(busy), 0);
            end
        end
    endtask

    // Aborts a map with an asynchronous reset between posedges.
    task automatic applyMidReset();
        int startCycle;
        loadMap();
        start = 1'b1;
        startCycle = cycle;
        @(posedge clk); #1;
        start = 1'b0;
        while (cycle - startCycle < 15) begin
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        flushModel();
        #1;
        checkOutput("rst_rd_en", DW'(bus.rd_en), 0);
        checkOutput("rst_rd_addr", DW'(bus.rd_addr), 0);
        checkOutput("rst_next", bus.next, 0);
        checkOutput("rst_conv_en", DW'(bus.conv_en), 0);
        checkOutput("rst_conv_rst", DW'(bus.conv_rst), 0);
        checkOutput("rst_win_valid", DW'(winValid), 0);
        checkOutput("rst_out_row", DW'(outRow), 0);
        checkOutput("rst_out_col", DW'(outCol), 0);
        checkOutput("rst_busy", DW'(busy), 0);
        checkOutput("rst_done", DW'(done), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idle_after_reset", DW'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        bus.rd_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", DW'(busy), 0);
        checkOutput("reset_rd_en", DW'(bus.rd_en), 0);
        checkOutput("reset_conv_en", DW'(bus.conv_en), 0);
        checkOutput("reset_done", DW'(done), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] plain map");
        applyStimulus(0, -1, -1, 0, 0, lat);
        checkOutput("latency_plain", DW'(lat), DW'(N + LAT + 3));

        $display("[TB] hold during cycles 10..14");
        applyStimulus(0, 10, 14, 0, 0, lat);
        checkOutput("latency_hold", DW'(lat), DW'(N + LAT + 3 + 5));

        $display("[TB] extra starts while busy");
        applyStimulus(0, -1, -1, 1, 1, lat);
        checkOutput("latency_extra_start", DW'(lat), DW'(N + LAT + 3));

        $display("[TB] reset mid-map");
        applyMidReset();
        applyStimulus(0, -1, -1, 0, 0, lat);
        checkOutput("latency_after_reset", DW'(lat), DW'(N + LAT + 3));

        $display("[TB] random back-to-back maps");
        for (int m = 0; m < 12; m++) begin
            applyStimulus($urandom_range(60), -1, -1, $urandom_range(1), $urandom_range(1), lat);
        end

        repeat (5) @(posedge clk);
        #1;
        checkOutput("no_maps_pending", DW'(mapsOutstanding), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
